// File: rtl/fir_serial_mac_ctrl.sv
// Serial 21-tap FIR: one shared 14x10 multiplier stepped through a circular sample
// buffer and coefficient ROM by a small scheduler FSM, valid/ready on both sides.
//
// state  | meaning
// IDLE   | waiting for an input sample (in_ready high when enabled)
// MAC    | one tap per cycle, NTAPS cycles, accumulating into r_acc
// ROUND  | round/truncate accumulator into the output register
// HOLD   | result presented, waiting for out_ready
module fir_serial_mac_ctrl #(
    parameter int NTAPS = 21,
    parameter int DW    = 14,
    parameter int CW    = 10,
    parameter int AW    = 25
) (
    input  logic          i_clk,
    input  logic          i_reset,
    input  logic          i_clk_enable,
    input  logic          i_in_valid,
    output logic          o_in_ready,
    input  logic [DW-1:0] i_in_data,
    output logic          o_out_valid,
    input  logic          i_out_ready,
    output logic [DW-1:0] o_out_data,
    output logic          o_busy
);

    localparam int PW    = DW + CW;
    localparam int RW    = AW - 2;
    localparam int FRAC  = CW - 1;
    localparam int PTR_W = $clog2(NTAPS);
    localparam logic [PTR_W-1:0] LAST_TAP = PTR_W'(NTAPS - 1);
    localparam logic [PTR_W-1:0] NTAPS_P  = PTR_W'(NTAPS);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_MAC   = 2'd1;
    localparam logic [1:0] S_ROUND = 2'd2;
    localparam logic [1:0] S_HOLD  = 2'd3;

    logic [1:0]              r_state;
    logic [DW-1:0]           r_buf [NTAPS];
    logic [PTR_W-1:0]        r_wptr;
    logic [PTR_W-1:0]        r_tap;
    logic signed [AW-1:0]    r_acc;
    logic [DW-1:0]           r_out_data;
    logic                    r_out_valid;

    logic [PTR_W-1:0]        w_rd_idx;
    logic signed [DW-1:0]    w_sample;
    logic signed [CW-1:0]    w_coef;
    logic signed [PW-1:0]    w_prod;
    logic [RW-1:0]           w_rnd_sum;
    logic                    w_unused_acc_msbs;

    // Modular subtraction stays correct in PTR_W bits since the true result is < NTAPS.
    assign w_rd_idx = (r_wptr >= r_tap) ? (r_wptr - r_tap) : (r_wptr + NTAPS_P - r_tap);
    assign w_sample = $signed(r_buf[w_rd_idx]);
    assign w_prod   = PW'(w_sample) * PW'(w_coef);

    always_comb begin
        w_coef = '0;
        case (r_tap)
            5'd0:    w_coef = -10'sd19;
            5'd1:    w_coef = -10'sd3;
            5'd2:    w_coef = 10'sd8;
            5'd3:    w_coef = -10'sd2;
            5'd4:    w_coef = 10'sd8;
            5'd5:    w_coef = 10'sd48;
            5'd6:    w_coef = 10'sd24;
            5'd7:    w_coef = -10'sd82;
            5'd8:    w_coef = -10'sd101;
            5'd9:    w_coef = 10'sd45;
            5'd10:   w_coef = 10'sd148;
            5'd11:   w_coef = 10'sd45;
            5'd12:   w_coef = -10'sd101;
            5'd13:   w_coef = -10'sd82;
            5'd14:   w_coef = 10'sd24;
            5'd15:   w_coef = 10'sd48;
            5'd16:   w_coef = 10'sd8;
            5'd17:   w_coef = -10'sd2;
            5'd18:   w_coef = 10'sd8;
            5'd19:   w_coef = -10'sd3;
            5'd20:   w_coef = -10'sd19;
            default: w_coef = '0;
        endcase
    end

    // Round to nearest, ties toward even result LSB; acc bits above RW wrap away.
    assign w_rnd_sum = r_acc[RW-1:0]
                     + {{(RW-CW+1){1'b0}}, r_acc[FRAC], {(FRAC-1){~r_acc[FRAC]}}};
    assign w_unused_acc_msbs = ^r_acc[AW-1:RW];

    assign o_in_ready  = i_clk_enable & (r_state == S_IDLE);
    assign o_busy      = (r_state != S_IDLE);
    assign o_out_valid = r_out_valid;
    assign o_out_data  = r_out_data;

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state     <= S_IDLE;
            r_wptr      <= '0;
            r_tap       <= '0;
            r_acc       <= '0;
            r_out_data  <= '0;
            r_out_valid <= 1'b0;
            for (int i = 0; i < NTAPS; i++) r_buf[i] <= '0;
        end else if (i_clk_enable) begin
            case (r_state)
                S_IDLE: begin
                    if (i_in_valid) begin
                        r_buf[r_wptr] <= i_in_data;
                        r_acc         <= '0;
                        r_tap         <= '0;
                        r_state       <= S_MAC;
                    end
                end
                S_MAC: begin
                    r_acc <= r_acc + AW'(w_prod);
                    if (r_tap == LAST_TAP) begin
                        r_tap   <= '0;
                        r_wptr  <= (r_wptr == LAST_TAP) ? '0 : r_wptr + 1'b1;
                        r_state <= S_ROUND;
                    end else begin
                        r_tap <= r_tap + 1'b1;
                    end
                end
                S_ROUND: begin
                    r_out_data  <= w_rnd_sum[RW-1:FRAC];
                    r_out_valid <= 1'b1;
                    r_state     <= S_HOLD;
                end
                S_HOLD: begin
                    if (i_out_ready) begin
                        r_out_valid <= 1'b0;
                        r_state     <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule
